// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the capture controller.
//   cap_state_t : capture FSM states
//   DEC_CNT_W   : width of the decimation counter
//   ENTRIES_DEF / ADDR_W_DEF : default capture RAM geometry
package capture_pkg;
  typedef enum logic [1:0] {IDLE, PRE, POST, DONE} cap_state_t;

  localparam int DEC_CNT_W   = 16;
  localparam int ENTRIES_DEF = 384;
  localparam int ADDR_W_DEF  = 9;
endpackage

// File: rtl/smpl_decimator.sv
// smpl_decimator: keeps one sample-valid in 2^dec.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the decimation counter (start of capture)
//   en         : counting enabled (capture in progress)
//   wrt_smpl   : sample valid
//   dec        : log2 of the decimation ratio
//   accept     : combinational, high when this sample is kept
module smpl_decimator
  import capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       wrt_smpl,
  input  logic [3:0] dec,
  output logic       accept
);

  logic [DEC_CNT_W-1:0] dec_cnt;
  logic [DEC_CNT_W-1:0] lim;

  assign lim    = (DEC_CNT_W'(1) << dec) - DEC_CNT_W'(1);
  assign accept = en & wrt_smpl & (dec_cnt == lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                dec_cnt <= '0;
    else if (clr)              dec_cnt <= '0;
    else if (en && wrt_smpl)   dec_cnt <= accept ? '0 : dec_cnt + DEC_CNT_W'(1);
  end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: decimates the sample stream into a circular capture RAM,
// arms once enough pre-trigger history is held, then collects trp
// post-trigger samples and reports the final write address.
//   run / clr_done      : start pulse / release from DONE
//   wrt_smpl, smpl      : incoming packed sample stream
//   triggered           : trigger hit level
//   decimator, trig_pos : ratio (log2) and post-trigger count, latched on run
//   we, waddr, wdata    : RAM write port (1 clk after accept)
//   armed, capturing, capture_done, last_addr : status
// Optional: define CAPTURE_ABORT_EN to add an abort input that drops an
// in-progress capture back to IDLE.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CAPTURE_ABORT_EN
  input  logic              abort,
`endif
  input  logic              run,
  input  logic              clr_done,
  input  logic              wrt_smpl,
  input  logic [7:0]        smpl,
  input  logic              triggered,
  input  logic [3:0]        decimator,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              armed,
  output logic              capturing,
  output logic              capture_done,
  output logic [ADDR_W-1:0] last_addr
);

  // pre_cnt must be able to hold ENTRIES itself
  localparam int                PCNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(ENTRIES - 1);
  localparam logic [PCNT_W-1:0] FULL   = PCNT_W'(ENTRIES);

  cap_state_t        state, state_nxt;
  logic [ADDR_W-1:0] wptr, trp, post_cnt;
  logic [PCNT_W-1:0] pre_cnt, pre_nxt, thr;
  logic [3:0]        dec;
  logic              accept, dec_en, post_end, abort_i;

`ifdef CAPTURE_ABORT_EN
  assign abort_i = abort & ((state == PRE) | (state == POST));
`else
  assign abort_i = 1'b0;
`endif

  // trp == 0 finishes POST without taking any further sample
  assign dec_en = ((state == PRE) | ((state == POST) & (trp != '0))) & ~abort_i;

  smpl_decimator u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      ((state == IDLE) & run),
    .en       (dec_en),
    .wrt_smpl (wrt_smpl),
    .dec      (dec),
    .accept   (accept)
  );

  assign thr      = FULL - {1'b0, trp};
  assign pre_nxt  = (accept && pre_cnt != FULL) ? pre_cnt + PCNT_W'(1) : pre_cnt;
  assign post_end = (trp == '0) | (accept & ((post_cnt + ADDR_W'(1)) == trp));

  assign capturing    = (state == PRE) | (state == POST);
  assign capture_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (run) state_nxt = PRE;
      PRE:  if (abort_i) state_nxt = IDLE;
            else if (triggered && armed) state_nxt = POST;
      POST: if (abort_i) state_nxt = IDLE;
            else if (post_end) state_nxt = DONE;
      DONE: if (clr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      wptr      <= '0;
      armed     <= 1'b0;
      last_addr <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      trp       <= '0;
      dec       <= '0;
    end else begin
      // write port runs independently of state so a pending strobe always issues
      we <= accept;
      if (accept) begin
        waddr <= wptr;
        wdata <= smpl;
        wptr  <= (wptr == LAST) ? '0 : wptr + ADDR_W'(1);
      end
      case (state)
        IDLE: if (run) begin
          wptr     <= '0;
          pre_cnt  <= '0;
          post_cnt <= '0;
          armed    <= 1'b0;
          trp      <= (trig_pos > LAST) ? LAST : trig_pos;
          dec      <= decimator;
        end
        PRE: if (abort_i) armed <= 1'b0;
        else begin
          pre_cnt <= pre_nxt;
          if (pre_nxt >= thr)     armed    <= 1'b1;
          if (state_nxt == POST)  post_cnt <= '0;
        end
        POST: if (abort_i) armed <= 1'b0;
        else begin
          if (accept) post_cnt <= post_cnt + ADDR_W'(1);
          if (post_end) begin
            // trp == 0: report the most recent pre-trigger write
            if (trp == '0) last_addr <= (wptr == '0) ? LAST : wptr - ADDR_W'(1);
            else           last_addr <= wptr;
          end
        end
        DONE: if (clr_done) armed <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed test of capture_ctrl with hand-computed
// expectations; a negedge monitor records every RAM write.
module tb_capture_ctrl;
  localparam int ENTRIES = 384;
  localparam int ADDR_W  = 9;

  logic              clk, rst_n, run, clr_done, wrt_smpl, triggered;
  logic [7:0]        smpl;
  logic [3:0]        decimator;
  logic [ADDR_W-1:0] trig_pos;
  logic              we, armed, capturing, capture_done;
  logic [ADDR_W-1:0] waddr, last_addr;
  logic [7:0]        wdata;
`ifdef CAPTURE_ABORT_EN
  logic              abort;
`endif

  capture_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef CAPTURE_ABORT_EN
    .abort        (abort),
`endif
    .run          (run),
    .clr_done     (clr_done),
    .wrt_smpl     (wrt_smpl),
    .smpl         (smpl),
    .triggered    (triggered),
    .decimator    (decimator),
    .trig_pos     (trig_pos),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .armed        (armed),
    .capturing    (capturing),
    .capture_done (capture_done),
    .last_addr    (last_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int we_cnt = 0, zero_cnt = 0, max_addr = 0, last_wa = 0, last_wd = 0;
  int wa_q[$], wd_q[$];

  always @(negedge clk) begin
    if (we === 1'b1) begin
      we_cnt  = we_cnt + 1;
      last_wa = int'(waddr);
      last_wd = int'(wdata);
      if (waddr == '0) zero_cnt = zero_cnt + 1;
      if (int'(waddr) > max_addr) max_addr = int'(waddr);
      wa_q.push_back(int'(waddr));
      wd_q.push_back(int'(wdata));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  int base, bq, bz;

  initial begin
    rst_n = 1'b0; run = 1'b0; clr_done = 1'b0; wrt_smpl = 1'b0; triggered = 1'b0;
    smpl = '0; decimator = '0; trig_pos = '0;
`ifdef CAPTURE_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    chk("rst_we", we, 0);
    chk("rst_armed", armed, 0);
    chk("rst_capturing", capturing, 0);
    chk("rst_done", capture_done, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_last_addr", last_addr, 0);
    tick; rst_n = 1'b1; tick;

    // T1: dec 0, trp 4, trigger on sample 500
    trig_pos = 4; run = 1'b1; tick; run = 1'b0;
    chk("t1_capturing", capturing, 1);
    chk("t1_armed0", armed, 0);
    wrt_smpl = 1'b1; base = we_cnt;
    for (int i = 0; i < 700 && !capture_done; i++) begin
      smpl = 8'(i); triggered = (i == 500);
      tick;
      if (i == 378) chk("t1_armed_379", armed, 0);
      if (i == 379) chk("t1_armed_380", armed, 1);
    end
    triggered = 1'b0;
    chk("t1_done", capture_done, 1);
    tick; tick; tick;  // wrt_smpl still high: ignored in DONE
    wrt_smpl = 1'b0; tick;
    chk("t1_we_cnt", we_cnt - base, 505);
    chk("t1_last_wa", last_wa, 120);
    chk("t1_last_wd", last_wd, 248);
    chk("t1_last_addr", last_addr, 120);
    chk("t1_armed_done", armed, 1);
    chk("t1_capturing_done", capturing, 0);

    // clr_done + run together: clr_done wins, run ignored
    clr_done = 1'b1; run = 1'b1; tick; clr_done = 1'b0; run = 1'b0;
    chk("clr_done_idle", capture_done, 0);
    chk("clr_armed", armed, 0);
    chk("clr_capturing", capturing, 0);
    tick;
    chk("clr_run_ignored", capturing, 0);

    // T2: dec 3, 64 sparse pulses; decimator change after run must be ignored
    trig_pos = 4; decimator = 4'd3; run = 1'b1; tick; run = 1'b0; decimator = 4'd0;
    bq = wa_q.size(); base = we_cnt;
    for (int n = 1; n <= 64; n++) begin
      smpl = 8'(n * 3); wrt_smpl = 1'b1; tick; wrt_smpl = 1'b0; tick;
    end
    chk("t2_we_cnt", we_cnt - base, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_addr%0d", k), wa_q[bq + k], k);
      chk($sformatf("t2_data%0d", k), wd_q[bq + k], ((k + 1) * 24) & 255);
    end
    // run during PRE ignored: pointer and latched dec keep going
    run = 1'b1; tick; run = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      smpl = 8'(200 + n); wrt_smpl = 1'b1; tick; wrt_smpl = 1'b0; tick;
    end
    chk("t2_run_ign_cnt", we_cnt - base, 9);
    chk("t2_run_ign_addr", last_wa, 8);
    chk("t2_run_ign_data", last_wd, 208);
    chk("t2_not_armed", armed, 0);
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;

    // T3: trigger held from run, trp 100
    trig_pos = 100; triggered = 1'b1; run = 1'b1; tick; run = 1'b0;
    wrt_smpl = 1'b1; base = we_cnt;
    for (int i = 0; i < 600 && !capture_done; i++) begin
      smpl = 8'(i); tick;
      if (i == 282) chk("t3_armed_283", armed, 0);
      if (i == 283) chk("t3_armed_284", armed, 1);
    end
    wrt_smpl = 1'b0; triggered = 1'b0; tick; tick;
    chk("t3_done", capture_done, 1);
    chk("t3_we_cnt", we_cnt - base, 385);
    chk("t3_last_addr", last_addr, 0);
    chk("t3_last_wa", last_wa, 0);
    clr_done = 1'b1; tick; clr_done = 1'b0;
    chk("t3_clr", capture_done, 0);

    // T4: wrap, trp 10, trigger after 1000 accepts on an idle cycle
    trig_pos = 10; run = 1'b1; tick; run = 1'b0;
    wrt_smpl = 1'b1; base = we_cnt; bz = zero_cnt;
    for (int i = 0; i < 1000; i++) begin
      smpl = 8'(i); tick;
    end
    wrt_smpl = 1'b0; triggered = 1'b1; tick; triggered = 1'b0;
    chk("t4_in_post", capturing, 1);
    chk("t4_not_done", capture_done, 0);
    wrt_smpl = 1'b1;
    for (int j = 0; j < 50 && !capture_done; j++) begin
      smpl = 8'(1000 + j); tick;
    end
    wrt_smpl = 1'b0; tick; tick;
    chk("t4_done", capture_done, 1);
    chk("t4_we_cnt", we_cnt - base, 1010);
    chk("t4_wraps", zero_cnt - bz, 3);
    chk("t4_max_addr", max_addr, 383);
    chk("t4_last_addr", last_addr, 241);
    chk("t4_last_wd", last_wd, 241);
    clr_done = 1'b1; tick; clr_done = 1'b0;

    // T5a: trig_pos above ENTRIES-1 clamps to 383 -> armed after 1 accept
    trig_pos = 9'd500; run = 1'b1; tick; run = 1'b0;
    chk("t5_armed0", armed, 0);
    smpl = 8'h5a; wrt_smpl = 1'b1; tick; wrt_smpl = 1'b0;
    chk("t5_armed1", armed, 1);
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;

    // T5b: trp 0 -> DONE the cycle after POST, no POST write
    trig_pos = 0; run = 1'b1; tick; run = 1'b0;
    wrt_smpl = 1'b1; base = we_cnt;
    for (int i = 0; i < 384; i++) begin
      smpl = 8'(i); tick;
      if (i == 382) chk("t5_armed_383", armed, 0);
    end
    wrt_smpl = 1'b0;
    chk("t5_armed_384", armed, 1);
    triggered = 1'b1; tick; triggered = 1'b0; wrt_smpl = 1'b1;
    chk("t5_post_not_done", capture_done, 0);
    tick;
    chk("t5_done", capture_done, 1);
    wrt_smpl = 1'b0; tick; tick;
    chk("t5_we_cnt", we_cnt - base, 384);
    chk("t5_last_addr", last_addr, 383);
    clr_done = 1'b1; tick; clr_done = 1'b0;

    // T6: reset mid-POST clears outputs immediately
    trig_pos = 50; run = 1'b1; tick; run = 1'b0; wrt_smpl = 1'b1;
    for (int i = 0; i < 340; i++) tick;
    triggered = 1'b1; tick; triggered = 1'b0; tick; tick;
    chk("t6_we_before", we, 1);
    chk("t6_armed_before", armed, 1);
    rst_n = 1'b0; #1;
    chk("t6_we_rst", we, 0);
    chk("t6_armed_rst", armed, 0);
    chk("t6_done_rst", capture_done, 0);
    chk("t6_capturing_rst", capturing, 0);
    chk("t6_waddr_rst", waddr, 0);
    wrt_smpl = 1'b0; tick; rst_n = 1'b1; tick;
    chk("t6_idle", capturing, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Downstream consumer of the packed 8-bit sample word produced by the channel sampling stage.
- Decimates the sample-valid stream, writes accepted samples into a circular capture RAM, and arms after enough pre-trigger samples.
- On trigger, collects a programmed number of post-trigger samples, then flags capture complete with the final write address so readback can unroll the buffer.

Parameters:
- ENTRIES, 384, capture RAM depth in samples.
- ADDR_W, 9, RAM address width; must satisfy 2^ADDR_W >= ENTRIES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  single-cycle start pulse.
- clr_done  input  1  single-cycle pulse; releases DONE back to IDLE.
- wrt_smpl  input  1  new packed sample valid on smpl this cycle.
- smpl  input  8  packed sample word from channel sampling stage.
- triggered  input  1  trigger-logic hit (level, may persist).
- decimator  input  4  keep one sample in 2^decimator.
- trig_pos  input  ADDR_W  number of post-trigger samples.
- we  output  1  RAM write strobe.
- waddr  output  ADDR_W  RAM write address.
- wdata  output  8  RAM write data.
- armed  output  1  pre-trigger quota met; trigger now honoured.
- capturing  output  1  state is PRE or POST.
- capture_done  output  1  state is DONE.
- last_addr  output  ADDR_W  address of final write of the completed capture.

Behaviour:
- Clocking and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: all outputs 0; state IDLE; all counters 0.
- FSM states: IDLE, PRE, POST, DONE.
- IDLE -> PRE on run.
  - Clear wptr, dec_cnt, pre_cnt and post_cnt.
  - Latch trp = min(trig_pos, ENTRIES-1).
  - Latch dec = decimator; later changes to decimator are ignored until the next run.
- Decimation, in PRE and POST only:
  - On wrt_smpl, accept the sample when dec_cnt == 2^dec - 1 and reset dec_cnt to 0; otherwise increment dec_cnt.
  - dec = 0 accepts every wrt_smpl.
  - dec_cnt is 16 bits.
- Write path, on accept:
  - Next cycle: we = 1, waddr = wptr, wdata = smpl as registered in the accept cycle. Latency is 1 clk.
  - wptr then increments and wraps ENTRIES-1 -> 0.
  - we is a single-cycle pulse; it is 0 when nothing is accepted.
- PRE state:
  - Each accept increments pre_cnt, saturating at ENTRIES.
  - armed = 1 (registered) once pre_cnt >= ENTRIES - trp.
  - When triggered = 1 and armed = 1 -> POST, post_cnt = 0.
  - triggered while not armed is ignored.
  - A sample accepted in the trigger cycle counts as a pre-trigger sample.
- POST state:
  - Each accept increments post_cnt.
  - When post_cnt reaches trp -> DONE; last_addr = address of the final write.
  - trp = 0: POST -> DONE on the next cycle; last_addr = last pre-trigger write address, or ENTRIES-1 if no write occurred.
- DONE state:
  - capture_done = 1, armed held at 1.
  - No writes; wrt_smpl is ignored.
  - clr_done -> IDLE and clears armed and capture_done.
- run while not IDLE is ignored.
- clr_done outside DONE is ignored.
- run and clr_done together in DONE: clr_done wins; run is ignored and requires a fresh pulse.
- rst_n asserted mid-capture returns everything to reset values immediately; RAM contents are undefined to this block.

Optional Feature:
- Macro: CAPTURE_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort in PRE or POST -> IDLE next cycle.
  - Clears armed and capturing; capture_done is not set.
  - A write strobe already pending in that cycle still issues.
- Undefined: no abort port; captures end only via DONE or reset.

Decomposition:
- Package capture_pkg:
  - cap_state_t enum {IDLE, PRE, POST, DONE}.
  - DEC_CNT_W = 16.
  - Default ENTRIES and ADDR_W constants.
- Sub-module smpl_decimator:
  - Holds dec_cnt.
  - Inputs: clk, rst_n, clr, en, wrt_smpl, dec.
  - Output: accept.

Test Plan:
- Reset; run; dec = 0, trp = 4, ENTRIES = 384; wrt_smpl every cycle, smpl = incrementing byte; trigger at cycle 500 -> armed after 380 accepts; DONE after 4 post writes; last_addr = (index of trigger-cycle write + 4) mod 384.
- dec = 3; 64 wrt_smpl pulses -> exactly 8 we pulses at addresses 0..7; wdata = smpl values from wrt_smpl #8, #16, ..., #64.
- triggered held high from run, trp = 100 -> stays PRE until 284th accept sets armed; POST begins next cycle; exactly 100 more writes follow.
- Wrap: trp = 10; trigger after 1000 accepts -> waddr wraps 383 -> 0 repeatedly; DONE with last_addr = (1009 mod 384) = 241.
- trig_pos = 500 (> ENTRIES-1) -> clamped to 383; armed after 1 accept; trp = 0 with trigger -> DONE next cycle, no extra we.
- run during PRE is ignored; clr_done and run together in DONE -> IDLE; rst_n low mid-POST -> we, armed and capture_done = 0 immediately.
